// File: rtl/lsu_split_gather_if.sv
// rtl/lsu_split_gather_if.sv - response-beat, writeback and error-flag bundle for lsu_split_gather
interface lsu_split_gather_if #(
    parameter int WARP_SIZE = 32,
    parameter int NUM_WARPS = 4,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 6
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [WW-1:0]               rsp_warp;
    logic [REG_W-1:0]            rsp_rd;
    logic [WARP_SIZE-1:0]        rsp_mask;
    logic [WARP_SIZE*DATA_W-1:0] rsp_data;
    logic                        rsp_last;

    logic                        wb_valid;
    logic                        wb_ready;
    logic [WW-1:0]               wb_warp;
    logic [REG_W-1:0]            wb_rd;
    logic [WARP_SIZE-1:0]        wb_mask;
    logic [WARP_SIZE*DATA_W-1:0] wb_data;

    logic                        err_overlap;
    logic                        err_rd;

    modport master (
        output rsp_valid, rsp_warp, rsp_rd, rsp_mask, rsp_data, rsp_last, wb_ready,
        input  rsp_ready, wb_valid, wb_warp, wb_rd, wb_mask, wb_data, err_overlap, err_rd
    );

    modport slave (
        input  rsp_valid, rsp_warp, rsp_rd, rsp_mask, rsp_data, rsp_last, wb_ready,
        output rsp_ready, wb_valid, wb_warp, wb_rd, wb_mask, wb_data, err_overlap, err_rd
    );
endinterface

// File: rtl/lsu_split_gather.sv
// rtl/lsu_split_gather.sv - merges split LSU load beats per warp into whole-warp writebacks
module lsu_split_gather #(
    parameter int WARP_SIZE = 32,
    parameter int NUM_WARPS = 4,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    lsu_split_gather_if.slave bus
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DW = WARP_SIZE * DATA_W;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]           state_q    [NUM_WARPS];
    logic [REG_W-1:0]     rd_q       [NUM_WARPS];
    logic [WARP_SIZE-1:0] acc_mask_q [NUM_WARPS];
    logic [DW-1:0]        acc_data_q [NUM_WARPS];

    logic          grant_valid_q, grant_valid_d;
    logic [WW-1:0] grant_q, grant_d;
    logic [WW-1:0] rr_ptr_q, rr_ptr_d;
    logic          err_overlap_q, err_rd_q;

    logic [DW-1:0] lane_bits;
    logic [1:0]    rsp_state;
    logic          accept;
    logic          wb_fire;
    logic          pick_found;
    logic [WW-1:0] pick;

    function automatic logic [WW-1:0] wrap_add(input logic [WW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_WARPS) s = s - NUM_WARPS;
        return WW'(s);
    endfunction

    // Ready depends only on registered slot state, never on wb_ready.
    assign rsp_state     = state_q[bus.rsp_warp];
    assign bus.rsp_ready = (rsp_state != S_DONE);
    assign accept        = bus.rsp_valid & bus.rsp_ready;
    assign wb_fire       = grant_valid_q & bus.wb_ready;

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            lane_bits[i*DATA_W +: DATA_W] = {DATA_W{bus.rsp_mask[i]}};
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            if (!pick_found && state_q[wrap_add(rr_ptr_q, k)] == S_DONE) begin
                pick_found = 1'b1;
                pick       = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // A held grant is never re-evaluated; a new choice is made only once it retires.
    always_comb begin
        grant_valid_d = grant_valid_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        if (wb_fire) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = wrap_add(grant_q, 1);
        end else if (!grant_valid_q && pick_found) begin
            grant_valid_d = 1'b1;
            grant_d       = pick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]    <= S_EMPTY;
                rd_q[w]       <= '0;
                acc_mask_q[w] <= '0;
                acc_data_q[w] <= '0;
            end
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            err_overlap_q <= 1'b0;
            err_rd_q      <= 1'b0;
        end else begin
            grant_valid_q <= grant_valid_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            if (wb_fire) begin
                state_q[grant_q] <= S_EMPTY;
            end
            // The retiring slot is DONE, so it can never be the slot accepting a beat.
            if (accept) begin
                if (rsp_state == S_EMPTY) begin
                    rd_q[bus.rsp_warp]       <= bus.rsp_rd;
                    acc_mask_q[bus.rsp_warp] <= bus.rsp_mask;
                    acc_data_q[bus.rsp_warp] <= bus.rsp_data & lane_bits;
                end else begin
                    acc_mask_q[bus.rsp_warp] <= acc_mask_q[bus.rsp_warp] | bus.rsp_mask;
                    acc_data_q[bus.rsp_warp] <= (acc_data_q[bus.rsp_warp] & ~lane_bits)
                                              | (bus.rsp_data & lane_bits);
                    if ((acc_mask_q[bus.rsp_warp] & bus.rsp_mask) != '0) err_overlap_q <= 1'b1;
                    if (rd_q[bus.rsp_warp] != bus.rsp_rd) err_rd_q <= 1'b1;
                end
                state_q[bus.rsp_warp] <= bus.rsp_last ? S_DONE : S_GATHER;
            end
        end
    end

    assign bus.wb_valid    = grant_valid_q;
    assign bus.wb_warp     = grant_valid_q ? grant_q : '0;
    assign bus.wb_rd       = grant_valid_q ? rd_q[grant_q] : '0;
    assign bus.wb_mask     = grant_valid_q ? acc_mask_q[grant_q] : '0;
    assign bus.wb_data     = grant_valid_q ? acc_data_q[grant_q] : '0;
    assign bus.err_overlap = err_overlap_q;
    assign bus.err_rd      = err_rd_q;
endmodule
